i2c_slave_regmap: RTL and testbench

Parametrised I2C target that exposes a bank of NUM_REGS byte registers through a register-pointer protocol.
- Supports multi-byte burst writes and reads with pointer auto-increment, repeated START, STOP detection, NACK on bad pointer, and true open-drain SDA.
- Sits between the board-level I2C pins and a host-side register file. The register file itself is external; this block drives a simple strobe interface to it.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_line_cond.sv | 47 ++++
 rtl/i2c_slave_regmap.sv | 245 ++++++++++++++++++++++++
 tb/tb_i2c_slave_regmap.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding and bus-level constants.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic        SDA_ACK  = 1'b0;
  localparam logic        SDA_NACK = 1'b1;
  localparam int unsigned RW_BIT   = 0;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA synchroniser with edge detection and START/STOP recognition.
module i2c_line_cond #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  input  logic gate,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Idle bus is high on both lines, so reset the chains to 1 to avoid false edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    scl_s    = scl_sync[SYNC_STAGES-1];
    sda_s    = sda_sync[SYNC_STAGES-1];
    scl_rise = scl_s & ~scl_d;
    scl_fall = ~scl_s & scl_d;
    start    = scl_s & scl_d & sda_d & ~sda_s & ~gate;
    stop     = scl_s & scl_d & ~sda_d & sda_s & ~gate;
  end

endmodule

// File: rtl/i2c_slave_regmap.sv
// I2C target exposing NUM_REGS byte registers through an auto-incrementing pointer,
// driving a strobe interface to an external register file.
module i2c_slave_regmap
  import i2c_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned PTR_W       = $clog2(NUM_REGS),
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_scl,
  inout  logic              i2c_sda,
  input  logic [ADDR_W-1:0] i_dev_addr,
  output logic [PTR_W-1:0]  o_reg_addr,
  output logic              o_reg_we,
  output logic [7:0]        o_reg_wdata,
  output logic              o_reg_re,
  input  logic [7:0]        i_reg_rdata,
  output logic              o_busy,
  output logic              o_xfer_done
);

  i2c_state_e        state;
  logic [3:0]        bit_cnt;
  logic [6:0]        shift;
  logic [7:0]        tx;
  logic [7:0]        rx_byte;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [ADDR_W-1:0] dev_addr_q;
  logic              rw;
  logic              sda_oe;
  logic              ack_phase;
  logic              rd_more;
  logic              rd_cap;
  logic              sda_s;
  logic              scl_rise;
  logic              scl_fall;
  logic              start;
  logic              stop;

  i2c_line_cond #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_cond (
    .clk      (clk),
    .rst      (rst),
    .scl      (i2c_scl),
    .sda      (i2c_sda),
    .gate     (sda_oe),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  always_comb begin
    rx_byte  = {shift, sda_s};
    ptr_next = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      tx          <= '0;
      ptr         <= '0;
      dev_addr_q  <= '0;
      rw          <= 1'b0;
      sda_oe      <= 1'b0;
      ack_phase   <= 1'b0;
      rd_more     <= 1'b0;
      rd_cap      <= 1'b0;
      o_reg_addr  <= '0;
      o_reg_we    <= 1'b0;
      o_reg_wdata <= '0;
      o_reg_re    <= 1'b0;
      o_busy      <= 1'b0;
      o_xfer_done <= 1'b0;
    end else begin
      o_reg_we    <= 1'b0;
      o_reg_re    <= 1'b0;
      o_xfer_done <= 1'b0;
      rd_cap      <= o_reg_re;

      // Read data arrives one clk after the strobe; in RDATA its MSB goes straight onto SDA.
      if (rd_cap) begin
        tx <= i_reg_rdata;
        if (state == ST_RDATA) sda_oe <= ~i_reg_rdata[7];
      end

      if (start) begin
        state      <= ST_ADDR;
        bit_cnt    <= '0;
        ack_phase  <= 1'b0;
        rd_more    <= 1'b0;
        sda_oe     <= 1'b0;
        dev_addr_q <= i_dev_addr;
      end else if (stop) begin
        state       <= ST_IDLE;
        ack_phase   <= 1'b0;
        rd_more     <= 1'b0;
        sda_oe      <= 1'b0;
        o_xfer_done <= o_busy;
        o_busy      <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (rx_byte[7:1] == dev_addr_q) begin
                  state  <= ST_ADDR_ACK;
                  rw     <= rx_byte[RW_BIT];
                  o_busy <= 1'b1;
                end else begin
                  state  <= ST_WAIT_STOP;
                  o_busy <= 1'b0;
                end
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                ack_phase <= 1'b1;
                sda_oe    <= ~SDA_ACK;
                if (rw) begin
                  o_reg_re   <= 1'b1;
                  o_reg_addr <= ptr;
                end
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                if (rw) begin
                  state  <= ST_RDATA;
                  sda_oe <= ~tx[7];
                end else begin
                  state  <= ST_PTR;
                  sda_oe <= 1'b0;
                end
              end
            end
          end

          ST_PTR: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
                  ptr   <= rx_byte[PTR_W-1:0];
                  state <= ST_PTR_ACK;
                end else begin
                  state  <= ST_WAIT_STOP;
                  o_busy <= 1'b0;
                end
              end
            end
          end

          ST_WDATA: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt     <= '0;
                o_reg_we    <= 1'b1;
                o_reg_addr  <= ptr;
                o_reg_wdata <= rx_byte;
                ptr         <= ptr_next;
                state       <= ST_WDATA_ACK;
              end
            end
          end

          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                ack_phase <= 1'b1;
                sda_oe    <= ~SDA_ACK;
              end else begin
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                bit_cnt   <= '0;
                state     <= ST_WDATA;
              end
            end
          end

          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                state   <= ST_RDATA_ACK;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                sda_oe <= ~tx[6];
              end
            end
          end

          ST_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s == SDA_NACK) begin
                state <= ST_WAIT_STOP;
              end else begin
                ptr     <= ptr_next;
                rd_more <= 1'b1;
              end
            end else if (scl_fall && rd_more) begin
              rd_more    <= 1'b0;
              o_reg_re   <= 1'b1;
              o_reg_addr <= ptr;
              bit_cnt    <= '0;
              state      <= ST_RDATA;
            end
          end

          ST_IDLE, ST_WAIT_STOP: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regmap.sv
// Scoreboard bench for i2c_slave_regmap: a bit-banged controller issues directed
// transactions while monitors compare register strobes and target-driven SDA bits.
module tb_i2c_slave_regmap;

  localparam int unsigned Q = 100;

  logic       clk;
  logic       rst;
  logic       scl;
  logic       ctl_low;
  logic       listen;
  logic [6:0] dev_addr;
  logic [3:0] reg_addr;
  logic       reg_we;
  logic [7:0] reg_wdata;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       xfer_done;
  wire        sda;

  pullup (sda);
  assign sda = ctl_low ? 1'b0 : 1'bz;

  i2c_slave_regmap #(
    .ADDR_W      (7),
    .NUM_REGS    (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i2c_scl     (scl),
    .i2c_sda     (sda),
    .i_dev_addr  (dev_addr),
    .o_reg_addr  (reg_addr),
    .o_reg_we    (reg_we),
    .o_reg_wdata (reg_wdata),
    .o_reg_re    (reg_re),
    .i_reg_rdata (reg_rdata),
    .o_busy      (busy),
    .o_xfer_done (xfer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External register file: each register reads back as {idx, ~idx}.
  always @(posedge clk) if (reg_re) reg_rdata <= {reg_addr, ~reg_addr};

  typedef struct { int kind; int addr; int data; } strobe_t;
  typedef struct { string name; int nbits; int val; } bus_t;

  strobe_t sq[$];
  bus_t    bq[$];
  int      n_checks = 0;
  int      n_errors = 0;
  int      bcnt = 0;
  logic [7:0] bacc = '0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_strobe(input int kind, input int addr, input int data);
    strobe_t s;
    s.kind = kind; s.addr = addr; s.data = data;
    sq.push_back(s);
  endtask

  task automatic exp_bus(input string name, input int nbits, input int val);
    bus_t b;
    b.name = name; b.nbits = nbits; b.val = val;
    bq.push_back(b);
  endtask

  task automatic sb_strobe(input int kind, input int addr, input int data);
    strobe_t e;
    if (sq.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL strobe_unexpected: got kind=%0d addr=%0d data=0x%0h expected none", kind, addr, data);
    end else begin
      e = sq.pop_front();
      check($sformatf("strobe_k%0d", e.kind), (kind << 16) | (addr << 8) | data,
            (e.kind << 16) | (e.addr << 8) | e.data);
    end
  endtask

  // Strobe monitor: kind 0 = write, 1 = read, 2 = transfer done.
  always @(negedge clk) begin
    if (reg_we)    sb_strobe(0, int'(reg_addr), int'(reg_wdata));
    if (reg_re)    sb_strobe(1, int'(reg_addr), 0);
    if (xfer_done) sb_strobe(2, 0, 0);
  end

  // Bus monitor: collects target-side bits on SCL rise and compares per ACK/byte.
  always @(posedge scl) begin
    if (listen) begin
      bacc = {bacc[6:0], sda};
      bcnt++;
      if (bq.size() == 0) begin
        n_checks++;
        n_errors++;
        bcnt = 0;
        $display("FAIL bus_unexpected: got bit %0b expected none", sda);
      end else if (bcnt == bq[0].nbits) begin
        check(bq[0].name, (bq[0].nbits == 8) ? int'(bacc) : int'(bacc[0]), bq[0].val);
        void'(bq.pop_front());
        bcnt = 0;
      end
    end
  end

  task automatic bit_out(input logic b);
    ctl_low = ~b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
    #Q;
  endtask

  task automatic bit_in();
    ctl_low = 1'b0;
    listen  = 1'b1;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
    listen = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    ctl_low = 1'b0;
    #Q scl = 1'b1;
    #Q ctl_low = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    ctl_low = 1'b1;
    #Q scl = 1'b1;
    #Q ctl_low = 1'b0;
    #Q;
  endtask

  task automatic write_byte(input string name, input logic [7:0] b, input int exp_ack);
    exp_bus(name, 1, exp_ack);
    for (int unsigned i = 0; i < 8; i++) bit_out(b[7-i]);
    bit_in();
  endtask

  task automatic read_byte(input string name, input int exp, input logic nack);
    exp_bus(name, 8, exp);
    for (int unsigned i = 0; i < 8; i++) bit_in();
    bit_out(nack);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    scl       = 1'b1;
    ctl_low   = 1'b0;
    listen    = 1'b0;
    dev_addr  = 7'h42;
    reg_rdata = '0;
    #23;
    check("rst_busy", int'(busy), 0);
    check("rst_we", int'(reg_we), 0);
    check("rst_re", int'(reg_re), 0);
    check("rst_done", int'(xfer_done), 0);
    check("rst_addr", int'(reg_addr), 0);
    check("rst_wdata", int'(reg_wdata), 0);
    check("rst_sda", int'(sda), 1);
    rst = 1'b1;
    #200;

    // 1: burst write at pointer 3
    exp_strobe(0, 3, 'hA5);
    exp_strobe(0, 4, 'h5A);
    i2c_start();
    write_byte("t1_addr_ack", 8'h84, 0);
    check("t1_busy", int'(busy), 1);
    write_byte("t1_ptr_ack", 8'h03, 0);
    write_byte("t1_d0_ack", 8'hA5, 0);
    write_byte("t1_d1_ack", 8'h5A, 0);
    exp_strobe(2, 0, 0);
    i2c_stop();
    check("t1_busy_end", int'(busy), 0);
    #400;

    // 2: pointer 15, repeated START, read two bytes across the wrap
    i2c_start();
    write_byte("t2_addr_ack", 8'h84, 0);
    write_byte("t2_ptr_ack", 8'h0F, 0);
    i2c_start();
    exp_strobe(1, 15, 0);
    write_byte("t2_raddr_ack", 8'h85, 0);
    exp_strobe(1, 0, 0);
    read_byte("t2_rd0", 'hF0, 1'b0);
    read_byte("t2_rd1", 'h0F, 1'b1);
    exp_strobe(2, 0, 0);
    i2c_stop();
    check("t2_busy_end", int'(busy), 0);
    #400;

    // 3: address mismatch
    i2c_start();
    write_byte("t3_addr_nack", 8'h86, 1);
    check("t3_busy", int'(busy), 0);
    write_byte("t3_data_nack", 8'h00, 1);
    i2c_stop();
    #400;

    // 4: pointer out of range
    i2c_start();
    write_byte("t4_addr_ack", 8'h84, 0);
    write_byte("t4_ptr_nack", 8'h10, 1);
    check("t4_busy", int'(busy), 0);
    write_byte("t4_data_nack", 8'h33, 1);
    i2c_stop();
    #400;

    // 5: reset while the target drives a 0 read bit
    i2c_start();
    write_byte("t5_addr_ack", 8'h84, 0);
    write_byte("t5_ptr_ack", 8'h05, 0);
    i2c_start();
    exp_strobe(1, 5, 0);
    write_byte("t5_raddr_ack", 8'h85, 0);
    check("t5_rd_drive", int'(sda), 0);
    rst = 1'b0;
    #1;
    check("t5_rst_sda", int'(sda), 1);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_addr", int'(reg_addr), 0);
    check("t5_rst_strobes", int'({reg_we, reg_re, xfer_done}), 0);
    #22 rst = 1'b1;
    #100;
    i2c_stop();
    #400;
    exp_strobe(0, 7, 'h99);
    i2c_start();
    write_byte("t5b_addr_ack", 8'h84, 0);
    write_byte("t5b_ptr_ack", 8'h07, 0);
    write_byte("t5b_data_ack", 8'h99, 0);
    exp_strobe(2, 0, 0);
    i2c_stop();
    #400;

    // 6: STOP after four data bits
    i2c_start();
    write_byte("t6_addr_ack", 8'h84, 0);
    write_byte("t6_ptr_ack", 8'h02, 0);
    bit_out(1'b1);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b0);
    exp_strobe(2, 0, 0);
    i2c_stop();
    check("t6_busy", int'(busy), 0);
    #1000;

    check("strobe_queue_left", sq.size(), 0);
    check("bus_queue_left", bq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
